// File: rtl/pe_stub_pkg.sv
// Shared definitions for the route-only grid PE: direction encoding and route field type.
package pe_stub_pkg;

   localparam int DIR_E = 0;
   localparam int DIR_W = 1;
   localparam int DIR_N = 2;
   localparam int DIR_S = 3;

   typedef logic [1:0] route_t;

endpackage

// File: rtl/pe_stub_fifo.sv
// Per-input word buffer: pointer-based FIFO with an extra wrap bit to tell full from empty.
module pe_stub_fifo
   import pe_stub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << AW;
   localparam int IW    = (AW > 0) ? AW : 1;

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [IW-1:0]    wr_idx, rd_idx;

   generate
      if (AW > 0) begin : g_idx
         assign wr_idx = wr_ptr_q[AW-1:0];
         assign rd_idx = rd_ptr_q[AW-1:0];
      end else begin : g_idx_single
         assign wr_idx = '0;
         assign rd_idx = '0;
      end
   endgenerate

   // Same slot, opposite wrap bit: writer is a full lap ahead.
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign dout  = mem_q[rd_idx];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (push && !full) begin
         mem_d[wr_idx] = din;
         wr_ptr_d      = wr_ptr_q + 1'b1;
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pe_route_stub.sv
// Route-only grid PE: buffers four directional streams and forwards each to a latched output direction.
module pe_route_stub
   import pe_stub_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_CH    = 4,
   parameter int FIFO_AW   = 2,
   parameter int CNT_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ap_start,
   output logic                    ap_idle,
   input  logic [2*NUM_CH-1:0]     route_cfg,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
   output logic [NUM_CH*WIDTH-1:0] out_data,
   output logic [NUM_CH-1:0]       out_valid,
   input  logic [NUM_CH-1:0]       out_ready,
   output logic [CNT_WIDTH-1:0]    fwd_count
);

   localparam int PW = $clog2(NUM_CH);

   route_t                  route_q [NUM_CH];
   route_t                  route_d [NUM_CH];
   logic                    ap_start_q, ap_start_d;
   logic [PW-1:0]           rr_q [NUM_CH];
   logic [PW-1:0]           rr_d [NUM_CH];
   logic [NUM_CH-1:0]       out_valid_q, out_valid_d;
   logic [NUM_CH*WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_WIDTH-1:0]    fwd_count_q, fwd_count_d;

   logic [NUM_CH-1:0]       fifo_full, fifo_empty, push, pop;
   logic [WIDTH-1:0]        fifo_head [NUM_CH];
   logic [PW:0]             hs_cnt;
   logic [PW-1:0]           idx;
   logic                    found;

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
         pe_stub_fifo #(.WIDTH(WIDTH), .AW(FIFO_AW)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (in_data[WIDTH*i +: WIDTH]),
            .dout  (fifo_head[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
         );
      end
   endgenerate

   // Readiness depends only on stored fullness, never on downstream out_ready.
   assign in_ready = ~fifo_full & {NUM_CH{ap_start & ~reset}};
   assign push     = in_valid & in_ready;

   assign ap_idle   = ~reset & ~ap_start & (&fifo_empty) & ~(|out_valid_q);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign fwd_count = fwd_count_q;

   always_comb begin
      ap_start_d = ap_start;
      route_d    = route_q;
      if (ap_start && !ap_start_q) begin
         for (int i = 0; i < NUM_CH; i++) begin
            route_d[i] = route_cfg[2*i +: 2];
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      rr_d        = rr_q;
      pop         = '0;
      hs_cnt      = '0;
      idx         = '0;
      found       = 1'b0;
      for (int j = 0; j < NUM_CH; j++) begin
         found = 1'b0;
         if (out_valid_q[j] && out_ready[j]) begin
            out_valid_d[j] = 1'b0;
            hs_cnt         = hs_cnt + 1'b1;
         end
         // Output register can take a new word if empty or draining this cycle.
         if (!out_valid_q[j] || out_ready[j]) begin
            for (int k = 0; k < NUM_CH; k++) begin
               idx = rr_q[j] + PW'(k);
               if (!found && !fifo_empty[idx] && route_q[idx] == route_t'(j)) begin
                  found                        = 1'b1;
                  pop[idx]                     = 1'b1;
                  out_valid_d[j]               = 1'b1;
                  out_data_d[WIDTH*j +: WIDTH] = fifo_head[idx];
                  rr_d[j]                      = idx + 1'b1;
               end
            end
         end
      end
      fwd_count_d = fwd_count_q + CNT_WIDTH'(hs_cnt);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         route_q     <= '{default: route_t'(DIR_E)};
         ap_start_q  <= 1'b0;
         rr_q        <= '{default: '0};
         out_valid_q <= '0;
         out_data_q  <= '0;
         fwd_count_q <= '0;
      end else begin
         route_q     <= route_d;
         ap_start_q  <= ap_start_d;
         rr_q        <= rr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         fwd_count_q <= fwd_count_d;
      end
   end

endmodule
